// File: rtl/arb_pkg.sv
// Shared types and constants for the cache-side memory port arbiter.
package arb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    I_BUSY = 2'd1,
    D_BUSY = 2'd2,
    DRAIN  = 2'd3
  } arb_state_t;

  localparam logic [1:0] SIZE_WORD = 2'b10;
  localparam logic [3:0] SEL_ALL   = 4'b1111;

  typedef struct packed {
    logic [31:0] addr;
    logic        write;
    logic [1:0]  size;
    logic [3:0]  sel;
    logic [31:0] wdata;
  } mem_req_t;

endpackage

// File: rtl/mem_port_arbiter.sv
// Shares the single axi_interface port between i_cache refills and d_cache accesses.
// Grant lands one cycle after IDLE sampling; ready is combinational from mem_ready; withdrawn requests are drained.
module mem_port_arbiter
  import arb_pkg::*;
#(
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        i_req,
  input  logic [31:0] i_addr,
  output logic        i_ready,
  input  logic        d_req,
  input  logic [31:0] d_addr,
  input  logic        d_write,
  input  logic [1:0]  d_size,
  input  logic [3:0]  d_sel,
  input  logic [31:0] d_wdata,
  output logic        d_ready,
  output logic [31:0] mem_a,
  output logic        mem_access,
  output logic        mem_write,
  output logic [1:0]  mem_size,
  output logic [3:0]  mem_sel,
  output logic [31:0] mem_st_data,
  input  logic        mem_ready,
  input  logic [31:0] mem_data,
  output logic [31:0] i_grant_cnt,
  output logic [31:0] d_grant_cnt
);

  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

  arb_state_t state;
  mem_req_t   req;
  logic [3:0] starve_cnt;
  logic       grant_i;

  // Read data is routed to the requesters outside this block.
  logic unused_mem_data;
  assign unused_mem_data = ^mem_data;

  // Instruction side wins ties until data has waited LIMIT grants.
  assign grant_i = i_req && (!d_req || (starve_cnt != LIMIT));

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state       <= IDLE;
      req         <= '0;
      starve_cnt  <= '0;
      i_grant_cnt <= '0;
      d_grant_cnt <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (grant_i) begin
            req   <= '{addr: i_addr, write: 1'b0, size: SIZE_WORD, sel: SEL_ALL, wdata: 32'd0};
            state <= I_BUSY;
            if (d_req && (starve_cnt < LIMIT)) starve_cnt <= starve_cnt + 4'd1;
          end else if (d_req) begin
            req        <= '{addr: d_addr, write: d_write, size: d_size, sel: d_sel, wdata: d_wdata};
            state      <= D_BUSY;
            starve_cnt <= '0;
          end
        end
        I_BUSY: begin
          if (mem_ready) begin
            i_grant_cnt <= i_grant_cnt + 32'd1;
            state       <= IDLE;
          end else if (!i_req) begin
            state <= DRAIN;
          end
        end
        D_BUSY: begin
          if (mem_ready) begin
            d_grant_cnt <= d_grant_cnt + 32'd1;
            state       <= IDLE;
          end else if (!d_req) begin
            state <= DRAIN;
          end
        end
        DRAIN: begin
          // The memory side cannot be cancelled, so finish it silently.
          if (mem_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign mem_access  = (state != IDLE);
  assign mem_a       = req.addr;
  assign mem_write   = req.write;
  assign mem_size    = req.size;
  assign mem_sel     = req.sel;
  assign mem_st_data = req.wdata;

  assign i_ready = (state == I_BUSY) && mem_ready;
  assign d_ready = (state == D_BUSY) && mem_ready;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: stimulus queues expected transactions, a monitor checks them.
module tb_mem_port_arbiter;

  logic        clk;
  logic        resetn;
  logic        i_req;
  logic [31:0] i_addr;
  logic        i_ready;
  logic        d_req;
  logic [31:0] d_addr;
  logic        d_write;
  logic [1:0]  d_size;
  logic [3:0]  d_sel;
  logic [31:0] d_wdata;
  logic        d_ready;
  logic [31:0] mem_a;
  logic        mem_access;
  logic        mem_write;
  logic [1:0]  mem_size;
  logic [3:0]  mem_sel;
  logic [31:0] mem_st_data;
  logic        mem_ready;
  logic [31:0] mem_data;
  logic [31:0] i_grant_cnt;
  logic [31:0] d_grant_cnt;

  mem_port_arbiter #(.STARVE_LIMIT(4)) dut (
    .clk(clk), .resetn(resetn),
    .i_req(i_req), .i_addr(i_addr), .i_ready(i_ready),
    .d_req(d_req), .d_addr(d_addr), .d_write(d_write), .d_size(d_size),
    .d_sel(d_sel), .d_wdata(d_wdata), .d_ready(d_ready),
    .mem_a(mem_a), .mem_access(mem_access), .mem_write(mem_write),
    .mem_size(mem_size), .mem_sel(mem_sel), .mem_st_data(mem_st_data),
    .mem_ready(mem_ready), .mem_data(mem_data),
    .i_grant_cnt(i_grant_cnt), .d_grant_cnt(d_grant_cnt)
  );

  // own: 0 = drained (no ready pulse), 1 = instruction, 2 = data
  typedef struct {
    int          own;
    logic [31:0] a;
    logic        w;
    logic [1:0]  sz;
    logic [3:0]  sel;
    logic [31:0] wd;
  } exp_t;

  exp_t exp_q[$];
  int   vectors = 0;
  int   miscompares = 0;
  int   resp_lat = 3;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", nm, act, req, $time);
    end
  endtask

  function automatic exp_t mk(input int own, input logic [31:0] a, input logic w,
                              input logic [1:0] sz, input logic [3:0] sel, input logic [31:0] wd);
    exp_t e;
    e.own = own; e.a = a; e.w = w; e.sz = sz; e.sel = sel; e.wd = wd;
    return e;
  endfunction

  // Memory-side responder: raises mem_ready for one cycle resp_lat cycles into a transaction.
  initial begin
    int cnt;
    cnt = 0;
    mem_ready = 1'b0;
    mem_data = 32'd0;
    forever begin
      @(posedge clk);
      #1;
      if (!resetn) begin
        mem_ready = 1'b0;
        cnt = 0;
      end else if (mem_ready) begin
        mem_ready = 1'b0;
        cnt = 0;
      end else if (mem_access) begin
        cnt++;
        if (cnt >= resp_lat) mem_ready = 1'b1;
      end
    end
  end

  // Monitor: checks held request fields every busy cycle and owner pulses on completion.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (resetn) begin
        if (i_ready || d_ready) chk("ready_overlap", 32'(i_ready & d_ready), 32'd0);
        if (mem_access) begin
          if (exp_q.size() == 0) begin
            chk("unexpected_access", 32'(mem_access), 32'd0);
          end else begin
            e = exp_q[0];
            chk("mem_a", mem_a, e.a);
            chk("mem_fields", {mem_write, mem_size, mem_sel}, {25'd0, e.w, e.sz, e.sel});
            chk("mem_st_data", mem_st_data, e.wd);
            if (mem_ready) begin
              chk("owner_ready", {30'd0, d_ready, i_ready},
                  {30'd0, (e.own == 2), (e.own == 1)});
              void'(exp_q.pop_front());
            end
          end
        end else if (i_ready || d_ready) begin
          chk("ready_when_idle", 32'(i_ready | d_ready), 32'd0);
        end
      end
    end
  end

  task automatic wait_done(input string nm);
    int n;
    n = 0;
    @(negedge clk);
    while (!(i_ready || d_ready) && n < 60) begin
      @(negedge clk);
      n++;
    end
    if (!(i_ready || d_ready)) begin
      vectors++;
      miscompares++;
      $display("FAIL timeout_%s: no ready pulse after %0d cycles, expected one", nm, n);
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    resetn = 1'b0;
    i_req = 1'b0; i_addr = 32'd0;
    d_req = 1'b0; d_addr = 32'd0; d_write = 1'b0; d_size = 2'd0; d_sel = 4'd0; d_wdata = 32'd0;
    #1;
    chk("rst_mem_access", 32'(mem_access), 32'd0);
    chk("rst_mem_a", mem_a, 32'd0);
    chk("rst_ready", {30'd0, i_ready, d_ready}, 32'd0);
    chk("rst_cnts", i_grant_cnt | d_grant_cnt, 32'd0);
    #21 resetn = 1'b1;
    @(posedge clk); #1;

    // Only-I, one-cycle grant latency
    resp_lat = 3;
    i_addr = 32'h0000_1F00; i_req = 1'b1;
    exp_q.push_back(mk(1, 32'h0000_1F00, 1'b0, 2'b10, 4'hF, 32'd0));
    @(posedge clk); #1;
    chk("grant_latency", 32'(mem_access), 32'd1);
    wait_done("only_i");
    i_req = 1'b0;
    chk("i_cnt_after_i", i_grant_cnt, 32'd1);

    // Only-D store with d_addr changing mid-flight
    d_addr = 32'h1000_0004; d_write = 1'b1; d_size = 2'b01; d_sel = 4'b0011; d_wdata = 32'h0000_A5A5;
    d_req = 1'b1;
    exp_q.push_back(mk(2, 32'h1000_0004, 1'b1, 2'b01, 4'b0011, 32'h0000_A5A5));
    @(posedge clk); #1;
    d_addr = 32'hDEAD_0000; d_wdata = 32'h1234_5678;
    wait_done("only_d");
    d_req = 1'b0;
    chk("d_cnt_after_d", d_grant_cnt, 32'd1);

    // Starvation bound: I,I,I,I,D,I,I,I,I,D
    resp_lat = 1;
    i_addr = 32'h0000_0100;
    d_addr = 32'h0000_2000; d_write = 1'b0; d_size = 2'b10; d_sel = 4'hF; d_wdata = 32'd0;
    for (int k = 0; k < 10; k++) begin
      if (k == 4 || k == 9) exp_q.push_back(mk(2, 32'h0000_2000, 1'b0, 2'b10, 4'hF, 32'd0));
      else                  exp_q.push_back(mk(1, 32'h0000_0100, 1'b0, 2'b10, 4'hF, 32'd0));
    end
    i_req = 1'b1; d_req = 1'b1;
    for (int k = 0; k < 10; k++) wait_done("starve");
    i_req = 1'b0; d_req = 1'b0;
    chk("i_cnt_after_starve", i_grant_cnt, 32'd9);
    chk("d_cnt_after_starve", d_grant_cnt, 32'd3);

    // Drain: I withdrawn right after grant, pending D served afterwards
    resp_lat = 4;
    i_addr = 32'h0000_4440;
    exp_q.push_back(mk(0, 32'h0000_4440, 1'b0, 2'b10, 4'hF, 32'd0));
    exp_q.push_back(mk(2, 32'h0000_2000, 1'b0, 2'b10, 4'hF, 32'd0));
    i_req = 1'b1; d_req = 1'b1;
    @(posedge clk); #1;
    i_req = 1'b0;
    wait_done("drain");
    d_req = 1'b0;
    chk("i_cnt_after_drain", i_grant_cnt, 32'd9);
    chk("d_cnt_after_drain", d_grant_cnt, 32'd4);

    // Reset in D_BUSY
    resp_lat = 10;
    d_addr = 32'h0000_3000; d_write = 1'b1; d_size = 2'b00; d_sel = 4'b0001; d_wdata = 32'h55;
    d_req = 1'b1;
    exp_q.push_back(mk(2, 32'h0000_3000, 1'b1, 2'b00, 4'b0001, 32'h55));
    @(posedge clk); #1;
    chk("busy_before_reset", 32'(mem_access), 32'd1);
    @(posedge clk); #2;
    resetn = 1'b0;
    exp_q.delete();
    #1;
    chk("rst2_mem_access", 32'(mem_access), 32'd0);
    chk("rst2_mem_a", mem_a, 32'd0);
    chk("rst2_fields", {mem_write, mem_size, mem_sel}, 32'd0);
    chk("rst2_st_data", mem_st_data, 32'd0);
    chk("rst2_d_ready", 32'(d_ready), 32'd0);
    chk("rst2_cnts", i_grant_cnt | d_grant_cnt, 32'd0);
    d_req = 1'b0;
    @(negedge clk); #2;
    resetn = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("no_access_after_reset", 32'(mem_access), 32'd0);
    resp_lat = 2;
    i_addr = 32'h0000_8000; i_req = 1'b1;
    exp_q.push_back(mk(1, 32'h0000_8000, 1'b0, 2'b10, 4'hF, 32'd0));
    wait_done("after_reset");
    i_req = 1'b0;
    chk("i_cnt_after_reset", i_grant_cnt, 32'd1);
    chk("d_cnt_after_reset", d_grant_cnt, 32'd0);

    repeat (3) @(posedge clk);
    #1;
    chk("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
